alu_mul_iter: RTL and testbench
===============================

# alu_mul_iter

Parametrised iterative integer multiplier for the execute stage. It replaces the fixed 64-bit, 1-bit-per-cycle, valid-hold multiplier with configurable width and bits-per-cycle, and supports the four RISC-V multiply flavours (MUL, MULH, MULHSU, MULHU). It uses a proper two-sided valid/ready handshake and a flush input. Latency is fixed and data-independent so the pipeline controller can schedule around it.

## Interface
Parameters:
- WIDTH, 64, operand and result width in bits; must be ≥ 4.
- RADIX_BITS, 1, multiplier bits consumed per BUSY cycle; must divide WIDTH. N = WIDTH/RADIX_BITS.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- flush  input  1  synchronous abort of any in-flight operation.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- op  input  2  00 MUL (low half), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
- a  input  WIDTH  multiplicand, rs1.
- b  input  WIDTH  multiplier, rs2.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  selected half of the product.
- busy  output  1  state ≠ IDLE.

## Operation
- States: IDLE → BUSY → FIX → DONE → IDLE.
- IDLE: in_ready=1. When in_valid && in_ready, capture op, the sign flags and the magnitudes of a and b.
  - a is signed for MULH and MULHSU.
  - b is signed for MULH only.
  - MUL is computed as unsigned; the low half is sign-agnostic.
  - Magnitude = two's-complement negation if the operand is signed and its MSB=1; held as WIDTH-bit unsigned (2^(WIDTH-1) fits).
  - Set neg = sign_a XOR sign_b. Load counter = N. Go to BUSY.
- BUSY, each cycle:
  - Partial = |a| × (low RADIX_BITS of the multiplier register), (WIDTH+RADIX_BITS) bits wide.
  - Add the partial into the upper accumulator, then shift the 2·WIDTH-bit {acc, multiplier} register right by RADIX_BITS.
  - Decrement the counter. Leave BUSY after the N-th BUSY cycle.
- FIX: if neg, product ← two's-complement negation of the 2·WIDTH-bit product. Select the low half (MUL) or high half (others) into the result register. Go to DONE.
- DONE: out_valid=1, result stable. On out_ready, go to IDLE.
- Captured operands are private: a, b and op changing after acceptance have no effect.
- No early termination: zero operands take full latency.
- flush or reset, in any state: next state IDLE, counter cleared, out_valid=0 the following cycle, in-flight result discarded. reset additionally clears the datapath and result to 0. reset has priority over flush.
- flush in the same cycle as an IDLE acceptance: request is dropped (flush wins).
- out_ready while not in DONE is ignored.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, result=0.
- Acceptance in cycle 0, i.e. in_valid && in_ready sampled at the end of cycle 0:
  - cycles 1..N BUSY;
  - cycle N+1 FIX;
  - out_valid first high in cycle N+2.
- WIDTH=64, RADIX_BITS=1: out_valid in cycle 66.
- in_ready is combinationally equal to (state==IDLE). No acceptance in the out_ready-handshake cycle; the next acceptance is at the earliest one cycle after the result handshake.
- Back-to-back throughput: one op per N+3 cycles when out_ready is held high.
- out_valid and result hold indefinitely while out_ready=0.
- out_valid, in_ready and busy are registered-state decodes only; there is no combinational path from in_valid or out_ready to outputs.

## Test plan
- Reset, then WIDTH=64, RADIX_BITS=1, MUL a=3, b=5, out_ready=1 → out_valid in cycle 66, result=15; in_ready=0 in cycles 1..66, 1 in cycle 67.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_FFFF_FFFE; MUL same operands → 0x1.
- MULH a=b=0x8000_0000_0000_0000 → 0x4000_0000_0000_0000; MULH a=-1, b=-1 → 0.
- MULHSU a=-1, b=2 → 0xFFFF_FFFF_FFFF_FFFF; MUL a=-1, b=2 → 0xFFFF_FFFF_FFFF_FFFE.
- Backpressure plus flush:
  - Hold out_ready=0 for 5 cycles after out_valid → result stable, in_ready=0, then the handshake completes.
  - Assert flush in BUSY cycle 10 → no out_valid, in_ready=1 next cycle; a following MUL 7×6 returns 42.
- WIDTH=8, RADIX_BITS=4: MULH a=b=0x80 → out_valid in cycle 4, result 0x40. Toggling a/b during BUSY has no effect.

Source files
------------

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative signed/unsigned multiplier, RADIX_BITS multiplier bits per cycle
// Fixed latency of N+2 cycles from acceptance to out_valid; product negated once at the end.

module alu_mul_iter #(
  parameter int WIDTH      = 64,
  parameter int RADIX_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = $clog2(N + 1);
  localparam int PW = WIDTH + RADIX_BITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  localparam logic [CW-1:0]      CNT_N  = CW'(N);
  localparam logic [CW-1:0]      CNT_1  = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2 * WIDTH)'(1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_op;
  logic               r_neg;
  logic [WIDTH-1:0]   r_mag_a;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_result;

  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [PW-1:0]      w_ext_a;
  logic [PW-1:0]      w_ext_m;
  logic [PW-1:0]      w_partial;
  logic [PW-1:0]      w_sum;
  logic [2*WIDTH-1:0] w_shifted;
  logic [2*WIDTH-1:0] w_fixed;

  assign w_sign_a = ((op == OP_MULH) || (op == OP_MULHSU)) && a[WIDTH-1];
  assign w_sign_b = (op == OP_MULH) && b[WIDTH-1];
  assign w_mag_a  = w_sign_a ? (~a + ONE_W) : a;
  assign w_mag_b  = w_sign_b ? (~b + ONE_W) : b;

  // The partial never exceeds PW bits, so the accumulator sum cannot overflow either.
  assign w_ext_a   = {{RADIX_BITS{1'b0}}, r_mag_a};
  assign w_ext_m   = {{WIDTH{1'b0}}, r_prod[RADIX_BITS-1:0]};
  assign w_partial = w_ext_a * w_ext_m;
  assign w_sum     = {{RADIX_BITS{1'b0}}, r_prod[2*WIDTH-1:WIDTH]} + w_partial;

  generate
    if (RADIX_BITS < WIDTH) begin : g_shift
      assign w_shifted = {w_sum, r_prod[WIDTH-1:RADIX_BITS]};
    end else begin : g_single
      assign w_shifted = w_sum;
    end
  endgenerate

  assign w_fixed = r_neg ? (~r_prod + ONE_2W) : r_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_mag_a  <= '0;
      r_prod   <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op    <= op;
            r_neg   <= w_sign_a ^ w_sign_b;
            r_mag_a <= w_mag_a;
            r_prod  <= {{WIDTH{1'b0}}, w_mag_b};
            r_cnt   <= CNT_N;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_prod <= w_shifted;
          r_cnt  <= r_cnt - CNT_1;
          if (r_cnt == CNT_1) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_prod   <= w_fixed;
          r_result <= (r_op == OP_MUL) ? w_fixed[WIDTH-1:0] : w_fixed[2*WIDTH-1:WIDTH];
          r_state  <= S_DONE;
        end
        default: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;

endmodule

// File: tb/tb_alu_mul_iter.sv
// tb/tb_alu_mul_iter.sv - directed bench for alu_mul_iter at 64x1 and 8x4 configurations

module tb_alu_mul_iter;

  logic        clk = 1'b0;
  logic        reset;

  logic        flush64, in_valid64, in_ready64, out_valid64, out_ready64, busy64;
  logic [1:0]  op64;
  logic [63:0] a64, b64, result64;

  logic        flush8, in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, result8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mul_iter #(.WIDTH(64), .RADIX_BITS(1)) u64 (
    .clk(clk), .reset(reset), .flush(flush64),
    .in_valid(in_valid64), .in_ready(in_ready64), .op(op64), .a(a64), .b(b64),
    .out_valid(out_valid64), .out_ready(out_ready64), .result(result64), .busy(busy64)
  );

  alu_mul_iter #(.WIDTH(8), .RADIX_BITS(4)) u8 (
    .clk(clk), .reset(reset), .flush(flush8),
    .in_valid(in_valid8), .in_ready(in_ready8), .op(op8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8), .busy(busy8)
  );

  // Issues one request on u64 with out_ready high; returns result and cycle of first out_valid.
  task automatic run64(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                       output logic [63:0] r, output int lat);
    @(negedge clk);
    op64 = o; a64 = x; b64 = y; in_valid64 = 1'b1; out_ready64 = 1'b1;
    @(negedge clk);
    in_valid64 = 1'b0;
    lat = 1;
    while (!out_valid64 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    r = result64;
    @(negedge clk);
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      output logic [7:0] r, output int lat);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    r = result8;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush64 = 0; in_valid64 = 0; out_ready64 = 0; op64 = 0; a64 = 0; b64 = 0;
    flush8 = 0; in_valid8 = 0; out_ready8 = 0; op8 = 0; a8 = 0; b8 = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if ({in_ready64, out_valid64, busy64} !== 3'b100) begin
      n_err++; $display("FAIL reset64_flags got=%b exp=100", {in_ready64, out_valid64, busy64});
    end
    n_vec++;
    if (result64 !== 64'h0) begin
      n_err++; $display("FAIL reset64_result got=%h exp=0", result64);
    end
    n_vec++;
    if ({in_ready8, out_valid8, busy8, result8} !== {3'b100, 8'h00}) begin
      n_err++; $display("FAIL reset8 got=%b/%h exp=100/00", {in_ready8, out_valid8, busy8}, result8);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    op64 = 2'b00; a64 = 64'd3; b64 = 64'd5; in_valid64 = 1'b1; out_ready64 = 1'b1;
    n_vec++;
    if (in_ready64 !== 1'b1) begin
      n_err++; $display("FAIL lat_ready_c0 got=%b exp=1", in_ready64);
    end
    @(negedge clk);
    in_valid64 = 1'b0;
    a64 = 64'hDEAD; b64 = 64'hBEEF; op64 = 2'b11;
    for (int c = 1; c <= 66; c++) begin
      n_vec++;
      if (in_ready64 !== 1'b0) begin
        n_err++; $display("FAIL lat_in_ready c=%0d got=%b exp=0", c, in_ready64);
      end
      n_vec++;
      if (out_valid64 !== (c == 66)) begin
        n_err++; $display("FAIL lat_out_valid c=%0d got=%b exp=%b", c, out_valid64, (c == 66));
      end
      if (c == 66) begin
        n_vec++;
        if (result64 !== 64'd15) begin
          n_err++; $display("FAIL lat_result got=%0d exp=15", result64);
        end
      end
      @(negedge clk);
    end
    n_vec++;
    if ({in_ready64, out_valid64} !== 2'b10) begin
      n_err++; $display("FAIL lat_c67 got=%b exp=10", {in_ready64, out_valid64});
    end
  endtask

  task automatic test_ops64();
    logic [63:0] r;
    int lat;
    run64(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, lat);
    n_vec++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFE || lat !== 66) begin
      n_err++; $display("FAIL mulhu_ones got=%h lat=%0d exp=fffffffffffffffe lat=66", r, lat);
    end
    run64(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, lat);
    n_vec++;
    if (r !== 64'h1) begin
      n_err++; $display("FAIL mul_ones got=%h exp=1", r);
    end
    run64(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, r, lat);
    n_vec++;
    if (r !== 64'h4000_0000_0000_0000) begin
      n_err++; $display("FAIL mulh_min got=%h exp=4000000000000000", r);
    end
    run64(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, lat);
    n_vec++;
    if (r !== 64'h0) begin
      n_err++; $display("FAIL mulh_m1 got=%h exp=0", r);
    end
    run64(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, r, lat);
    n_vec++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_err++; $display("FAIL mulhsu_m1x2 got=%h exp=ffffffffffffffff", r);
    end
    run64(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, r, lat);
    n_vec++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_err++; $display("FAIL mul_m1x2 got=%h exp=fffffffffffffffe", r);
    end
    run64(2'b11, 64'h0, 64'h0, r, lat);
    n_vec++;
    if (r !== 64'h0 || lat !== 66) begin
      n_err++; $display("FAIL mulhu_zero got=%h lat=%0d exp=0 lat=66", r, lat);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    op64 = 2'b00; a64 = 64'd9; b64 = 64'd11; in_valid64 = 1'b1; out_ready64 = 1'b1;
    @(negedge clk);
    in_valid64 = 1'b0;
    repeat (64) @(negedge clk);
    out_ready64 = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      n_vec++;
      if ({out_valid64, in_ready64} !== 2'b10 || result64 !== 64'd99) begin
        n_err++; $display("FAIL bp_hold c=%0d got=%b/%0d exp=10/99", c, {out_valid64, in_ready64}, result64);
      end
      if (c < 5) @(negedge clk);
    end
    out_ready64 = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({out_valid64, in_ready64, busy64} !== 3'b010) begin
      n_err++; $display("FAIL bp_release got=%b exp=010", {out_valid64, in_ready64, busy64});
    end
  endtask

  task automatic test_flush();
    logic [63:0] r;
    int lat;
    int seen;
    @(negedge clk);
    op64 = 2'b00; a64 = 64'd5; b64 = 64'd5; in_valid64 = 1'b1; flush64 = 1'b1;
    @(negedge clk);
    in_valid64 = 1'b0; flush64 = 1'b0;
    n_vec++;
    if ({busy64, in_ready64} !== 2'b01) begin
      n_err++; $display("FAIL flush_accept got=%b exp=01", {busy64, in_ready64});
    end
    op64 = 2'b00; a64 = 64'd123; b64 = 64'd456; in_valid64 = 1'b1; out_ready64 = 1'b1;
    @(negedge clk);
    in_valid64 = 1'b0;
    repeat (9) @(negedge clk);
    n_vec++;
    if (busy64 !== 1'b1) begin
      n_err++; $display("FAIL flush_busy10 got=%b exp=1", busy64);
    end
    flush64 = 1'b1;
    @(negedge clk);
    flush64 = 1'b0;
    n_vec++;
    if ({in_ready64, out_valid64, busy64} !== 3'b100) begin
      n_err++; $display("FAIL flush_idle got=%b exp=100", {in_ready64, out_valid64, busy64});
    end
    seen = 0;
    for (int c = 0; c < 70; c++) begin
      if (out_valid64) seen++;
      @(negedge clk);
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++; $display("FAIL flush_no_result got=%0d exp=0", seen);
    end
    run64(2'b00, 64'd7, 64'd6, r, lat);
    n_vec++;
    if (r !== 64'd42 || lat !== 66) begin
      n_err++; $display("FAIL flush_next got=%0d lat=%0d exp=42 lat=66", r, lat);
    end
  endtask

  task automatic test_radix4();
    logic [7:0] r;
    int lat;
    @(negedge clk);
    op8 = 2'b01; a8 = 8'h80; b8 = 8'h80; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom);
      n_vec++;
      if (out_valid8 !== (c == 4) || in_ready8 !== (c == 5)) begin
        n_err++; $display("FAIL r4_timing c=%0d got=%b%b exp=%b%b", c, out_valid8, in_ready8, (c == 4), (c == 5));
      end
      if (c == 4) begin
        n_vec++;
        if (result8 !== 8'h40) begin
          n_err++; $display("FAIL r4_mulh got=%h exp=40", result8);
        end
      end
      @(negedge clk);
    end
    run8(2'b00, 8'hFF, 8'hFF, r, lat);
    n_vec++;
    if (r !== 8'h01 || lat !== 4) begin
      n_err++; $display("FAIL r4_mul got=%h lat=%0d exp=01 lat=4", r, lat);
    end
    run8(2'b10, 8'hFF, 8'h02, r, lat);
    n_vec++;
    if (r !== 8'hFF) begin
      n_err++; $display("FAIL r4_mulhsu got=%h exp=ff", r);
    end
    run8(2'b11, 8'hC8, 8'h64, r, lat);
    n_vec++;
    if (r !== 8'h4E) begin
      n_err++; $display("FAIL r4_mulhu got=%h exp=4e", r);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    op8 = 2'b00; a8 = 8'd3; b8 = 8'd4; in_valid8 = 1'b1; out_ready8 = 1'b1;
    for (int c = 0; c < 15; c++) begin
      n_vec++;
      if (out_valid8 !== ((c % 5) == 4) || in_ready8 !== ((c % 5) == 0)) begin
        n_err++; $display("FAIL b2b c=%0d got=%b%b exp=%b%b", c, out_valid8, in_ready8, ((c % 5) == 4), ((c % 5) == 0));
      end
      if ((c % 5) == 4) begin
        n_vec++;
        if (result8 !== 8'd12) begin
          n_err++; $display("FAIL b2b_result c=%0d got=%0d exp=12", c, result8);
        end
      end
      @(negedge clk);
    end
    in_valid8 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ops64();
    test_backpressure();
    test_flush();
    test_radix4();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
